clock_gen: RTL and testbench



---
 rtl/clock_pkg.sv | 4 +
 rtl/clock_gen.sv | 65 ++++++
 tb/tb_clock_gen.sv | 136 +++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared state type for the clock generator.
package clock_pkg;
  typedef enum logic {IDLE, RUN} clk_state_t;
endpackage

// File: rtl/clock_gen.sv
// clock_gen: divided clock with glitch-free start/stop, edge strobes and a rise counter.
module clock_gen
  import clock_pkg::*;
#(
  parameter int PERIOD = 10,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] period_count,
  output logic             running
);
  localparam int HIGH = PERIOD / 2;
  localparam int LOW  = PERIOD - HIGH;
  localparam int PW   = $clog2(PERIOD);
  localparam logic [PW-1:0] LOW_P  = PW'(LOW);
  localparam logic [PW-1:0] LAST_P = PW'(PERIOD - 1);
  if (PERIOD < 2) begin : g_period_check
    $error("clock_gen: PERIOD must be at least 2");
  end
  clk_state_t state, state_n;
  logic [PW-1:0] phase, phase_n;
  logic out_n, rise_n, fall_n;
  always_comb begin
    state_n = state;
    phase_n = '0;
    out_n   = 1'b0;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    if (state == IDLE) begin
      state_n = enable ? RUN : IDLE;
    end else if (phase != LAST_P) begin
      phase_n = phase + PW'(1);
      out_n   = phase_n >= LOW_P;
      rise_n  = phase_n == LOW_P;
    end else begin
      // end of period: clk_out always falls here, stop only takes effect now
      state_n = enable ? RUN : IDLE;
      fall_n  = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      phase        <= '0;
      clk_out      <= 1'b0;
      rise_tick    <= 1'b0;
      fall_tick    <= 1'b0;
      period_count <= '0;
      running      <= 1'b0;
    end else begin
      state        <= state_n;
      phase        <= phase_n;
      clk_out      <= out_n;
      rise_tick    <= rise_n;
      fall_tick    <= fall_n;
      period_count <= period_count + CNT_W'(rise_n);
      running      <= state_n == RUN;
    end
  end
endmodule

// File: tb/tb_clock_gen.sv
// tb_clock_gen: three clock_gen configurations checked against a cycle-count reference model.
module tb_clock_gen;
  localparam int N = 3;
  int unsigned p_of [N] = '{10, 5, 2};
  logic [31:0] mask [N] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_000F};
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] en = '0;
  logic [N-1:0] co, rt, ft, rn;
  logic [31:0] pc10, pc5;
  logic [3:0]  pc2;
  logic [31:0] pc [N];
  assign pc[0] = pc10;
  assign pc[1] = pc5;
  assign pc[2] = {28'b0, pc2};
  int vectors = 0;
  int miscompares = 0;
  bit          m_run  [N];
  int unsigned m_k    [N];
  logic        m_out  [N];
  logic        m_rise [N];
  logic        m_fall [N];
  logic [31:0] m_cnt  [N];

  always #5 clk = ~clk;

  clock_gen #(.PERIOD(10), .CNT_W(32)) u10 (.clk(clk), .reset(reset), .enable(en[0]),
    .clk_out(co[0]), .rise_tick(rt[0]), .fall_tick(ft[0]), .period_count(pc10), .running(rn[0]));
  clock_gen #(.PERIOD(5), .CNT_W(32)) u5 (.clk(clk), .reset(reset), .enable(en[1]),
    .clk_out(co[1]), .rise_tick(rt[1]), .fall_tick(ft[1]), .period_count(pc5), .running(rn[1]));
  clock_gen #(.PERIOD(2), .CNT_W(4)) u2 (.clk(clk), .reset(reset), .enable(en[2]),
    .clk_out(co[2]), .rise_tick(rt[2]), .fall_tick(ft[2]), .period_count(pc2), .running(rn[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Position within the period is just elapsed cycles since start modulo PERIOD.
  task automatic model(input int i);
    int unsigned p, low, pos;
    p   = p_of[i];
    low = p - p / 2;
    m_rise[i] = 1'b0;
    m_fall[i] = 1'b0;
    if (reset) begin
      m_run[i] = 1'b0; m_k[i] = 0; m_out[i] = 1'b0; m_cnt[i] = '0;
    end else if (!m_run[i]) begin
      m_out[i] = 1'b0;
      if (en[i]) begin m_run[i] = 1'b1; m_k[i] = 0; end
    end else if (m_k[i] % p == p - 1) begin
      m_out[i]  = 1'b0;
      m_fall[i] = 1'b1;
      if (en[i]) m_k[i]++; else m_run[i] = 1'b0;
    end else begin
      m_k[i]++;
      pos = m_k[i] % p;
      m_out[i]  = pos >= low;
      m_rise[i] = pos == low;
      if (m_rise[i]) m_cnt[i] = (m_cnt[i] + 1) & mask[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < N; i++) model(i);
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("u%0d_clk_out", i), {31'b0, co[i]}, {31'b0, m_out[i]});
      check($sformatf("u%0d_rise_tick", i), {31'b0, rt[i]}, {31'b0, m_rise[i]});
      check($sformatf("u%0d_fall_tick", i), {31'b0, ft[i]}, {31'b0, m_fall[i]});
      check($sformatf("u%0d_running", i), {31'b0, rn[i]}, {31'b0, m_run[i]});
      check($sformatf("u%0d_period_count", i), pc[i], m_cnt[i]);
      check($sformatf("u%0d_tick_overlap", i), {31'b0, rt[i] & ft[i]}, 32'd0);
    end
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    en = '0;
    tick();
    tick();
    check("reset_clk_out", {29'b0, co}, 32'd0);
    check("reset_count10", pc[0], 32'd0);
    reset = 1'b0;
    en = '1;
    tick();
    for (int n = 1; n <= 31; n++) begin
      tick();
      if (n == 5)  check("p10_first_rise_S5", {31'b0, rt[0]}, 32'd1);
      if (n == 10) check("p10_first_fall_S10", {31'b0, ft[0]}, 32'd1);
      if (n == 25) check("p10_count_S25", pc[0], 32'd3);
      if (n == 29) check("p2_count_15", pc[2], 32'd15);
      if (n == 31) check("p2_count_wrap", pc[2], 32'd0);
    end
    guard = 0;
    while (!(m_run[0] && m_k[0] % 10 == 6) && guard < 20) begin tick(); guard++; end
    check("wait_phase6", {31'b0, guard < 20}, 32'd1);
    en[0] = 1'b0;
    tick();
    check("stop_high_ph7", {31'b0, co[0]}, 32'd1);
    tick();
    tick();
    tick();
    check("stop_fall_tick", {31'b0, ft[0]}, 32'd1);
    check("stop_idle", {31'b0, rn[0]}, 32'd0);
    tick();
    tick();
    check("stop_held_low", {31'b0, co[0]}, 32'd0);
    en[0] = 1'b1;
    guard = 0;
    while (!(m_run[0] && m_k[0] % 10 == 7) && guard < 30) begin tick(); guard++; end
    check("wait_phase7", {31'b0, guard < 30}, 32'd1);
    reset = 1'b1;
    tick();
    check("rst_mid_high_clk_out", {31'b0, co[0]}, 32'd0);
    check("rst_no_fall_tick", {31'b0, ft[0]}, 32'd0);
    check("rst_count", pc[0], 32'd0);
    reset = 1'b0;
    tick();
    repeat (4) tick();
    tick();
    check("restart_rise_S5", {31'b0, rt[0]}, 32'd1);
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++) en[i] = $urandom_range(0, 3) != 0;
      reset = $urandom_range(0, 59) == 0;
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
